pipeline_uart_rx: RTL

PIPELINE_UART_RX -- requirements
Module: pipeline_uart_rx

---
 rtl/pipeline_uart_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_uart_rx.sv
// pipeline_uart_rx: oversampling UART receiver (start, DATA_BITS data bits LSB first,
// optional even parity, one stop bit). The line is resynchronised into rx_s and every
// decision is taken on a sample_tick at the middle of a bit period.
// Optional feature: define UART_RX_PARITY_EN to receive and check one even-parity bit
// after the data bits; without it parity_err is held at 0.
module pipeline_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   rx_meta;
  logic                   rx_s;
  logic [DATA_BITS-1:0]   shift_reg;

`ifdef UART_RX_PARITY_EN
  logic                   par_bit;

  // Even parity: data ones plus the parity bit must add up to an even count.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Payload capture: shift in LSB first at each data mid-bit (no reset needed on data).
  always_ff @(posedge sysclk) begin
    if (sample_tick && state == ST_DATA && tick_cnt == TICK_LAST) begin
      shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
`ifdef UART_RX_PARITY_EN
    if (sample_tick && state == ST_PARITY && tick_cnt == TICK_LAST) begin
      par_bit <= rx_s;
    end
`endif
  end

  // Receive FSM; status pulses are registered and cleared on the following sysclk.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (sample_tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end

          ST_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // A start bit that is high again at mid-bit was only a glitch.
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= ST_PARITY;
`else
                state   <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif

          ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                // Bad stop bit wins over a parity result; wait out any break.
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
              end else if (parity_bad(shift_reg, par_bit)) begin
                parity_err <= 1'b1;
                state      <= ST_IDLE;
`endif
              end else begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_WAIT_HIGH: begin
            if (rx_s) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
